// File: rtl/uart_rx_sym_ctrl.sv
// UART 10b/8b receive sequencer: frames start + 10 coded bits + stop from rx_i,
// presents the symbol to an external decoder and hands the byte out with valid/ready.
// Optional weight check: define SYM_WEIGHT_CHECK_EN.
// Ports: clk, rst (async, active-high), rx_i (serial in), sym_o/bit_cnto (to decoder),
//   dec_data_i (from decoder), rx_data_o/rx_valid_o/rx_ready_i (consumer handshake),
//   busy_o, frame_err_o, overrun_o, code_err_o (status; the last three are 1-cycle pulses).
module uart_rx_sym_ctrl #(
   parameter int CLKS_PER_BIT = 434,
   parameter int CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [9:0] sym_o,
   output logic [9:0] bit_cnto,
   input  logic [7:0] dec_data_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       code_err_o
);

   localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP, PRESENT, BRK
   } state_t;

   state_t           state, state_nx;
   logic             rx_m, rx_s;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [9:0]       sym, sym_nx;
   logic [9:0]       bit_cnt, bit_cnt_nx;
   logic [7:0]       data, data_nx;
   logic             valid, valid_nx;
   logic             ferr, ferr_nx;
   logic             ovr, ovr_nx;
   logic             cerr, cerr_nx;
   logic             weight_ok;

`ifdef SYM_WEIGHT_CHECK_EN
   logic [3:0] weight;
   assign weight    = 4'($countones(sym));
   assign weight_ok = (weight >= 4'd4) && (weight <= 4'd6);
`else
   assign weight_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         state   <= IDLE;
         cnt     <= '0;
         sym     <= '0;
         bit_cnt <= '0;
         data    <= '0;
         valid   <= 1'b0;
         ferr    <= 1'b0;
         ovr     <= 1'b0;
         cerr    <= 1'b0;
      end else begin
         rx_m    <= rx_i;
         rx_s    <= rx_m;
         state   <= state_nx;
         cnt     <= cnt_nx;
         sym     <= sym_nx;
         bit_cnt <= bit_cnt_nx;
         data    <= data_nx;
         valid   <= valid_nx;
         ferr    <= ferr_nx;
         ovr     <= ovr_nx;
         cerr    <= cerr_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt + 1'b1;
      sym_nx     = sym;
      bit_cnt_nx = bit_cnt;
      data_nx    = data;
      valid_nx   = valid;
      ferr_nx    = 1'b0;
      ovr_nx     = 1'b0;
      cerr_nx    = 1'b0;
      if (valid && rx_ready_i)
         valid_nx = 1'b0;
      unique case (state)
         IDLE: begin
            cnt_nx     = '0;
            bit_cnt_nx = '0;
            if (!rx_s)
               state_nx = START;
         end
         START: begin
            if (cnt == HALF) begin
               cnt_nx = '0;
               if (!rx_s) begin
                  state_nx   = DATA;
                  bit_cnt_nx = 10'd1;
                  sym_nx     = '0;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         DATA: begin
            if (cnt == LAST) begin
               cnt_nx     = '0;
               sym_nx     = {rx_s, sym[9:1]};
               bit_cnt_nx = bit_cnt + 10'd1;
               if (bit_cnt == 10'd10)
                  state_nx = STOP;
            end
         end
         STOP: begin
            if (cnt == LAST) begin
               cnt_nx = '0;
               if (rx_s) begin
                  state_nx = PRESENT;
               end else begin
                  // Symbol is discarded: hide it from the decoder qualifier.
                  state_nx   = BRK;
                  ferr_nx    = 1'b1;
                  bit_cnt_nx = '0;
               end
            end
         end
         BRK: begin
            cnt_nx = '0;
            if (rx_s)
               state_nx = IDLE;
         end
         PRESENT: begin
            cnt_nx     = '0;
            bit_cnt_nx = '0;
            state_nx   = IDLE;
            if (!weight_ok) begin
               cerr_nx = 1'b1;
            end else if (!valid || rx_ready_i) begin
               // A same-cycle consume frees the slot for the new byte.
               data_nx  = dec_data_i;
               valid_nx = 1'b1;
            end else begin
               ovr_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign sym_o       = sym;
   assign bit_cnto    = bit_cnt;
   assign rx_data_o   = data;
   assign rx_valid_o  = valid;
   assign busy_o      = (state != IDLE);
   assign frame_err_o = ferr;
   assign overrun_o   = ovr;
   assign code_err_o  = cerr;

endmodule

// File: tb/tb_uart_rx_sym_ctrl.sv
// Self-checking bench for uart_rx_sym_ctrl with CLKS_PER_BIT=16.
// Decoder model: byte = sym[7:0] ^ 8'h27; expected bytes kept in a scoreboard queue.
module tb_uart_rx_sym_ctrl;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_i;
   logic [9:0] sym_o;
   logic [9:0] bit_cnto;
   logic [7:0] dec_data_i;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_ready_i;
   logic       busy_o;
   logic       frame_err_o;
   logic       overrun_o;
   logic       code_err_o;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];

   int         ferr_n = 0, ovr_n = 0, cerr_n = 0, pres_n = 0, busy_n = 0;
   logic [9:0] prev_bc = '0, prev_sym = '0, pres_sym = '0;
   logic       prev_busy = 1'b0, prev_valid = 1'b0;
   logic       pres_vb = 1'b0, pres_va = 1'b0;

   uart_rx_sym_ctrl #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .rx_i(rx_i), .sym_o(sym_o), .bit_cnto(bit_cnto),
      .dec_data_i(dec_data_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .rx_ready_i(rx_ready_i), .busy_o(busy_o), .frame_err_o(frame_err_o),
      .overrun_o(overrun_o), .code_err_o(code_err_o)
   );

   always #5 clk = ~clk;

   assign dec_data_i = sym_o[7:0] ^ 8'h27;

   // Event monitor: counts pulses and records each PRESENT cycle as it ends.
   always @(negedge clk) begin
      if (frame_err_o) ferr_n <= ferr_n + 1;
      if (overrun_o)   ovr_n  <= ovr_n + 1;
      if (code_err_o)  cerr_n <= cerr_n + 1;
      if (busy_o)      busy_n <= busy_n + 1;
      if (prev_bc == 10'd11 && prev_busy && bit_cnto == 10'd0 && !busy_o) begin
         pres_n   <= pres_n + 1;
         pres_sym <= prev_sym;
         pres_vb  <= prev_valid;
         pres_va  <= rx_valid_o;
      end
      prev_bc    <= bit_cnto;
      prev_sym   <= sym_o;
      prev_busy  <= busy_o;
      prev_valid <= rx_valid_o;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_bit(input logic b);
      rx_i = b;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [9:0] s, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 10; i++) drive_bit(s[i]);
      drive_bit(stop);
      rx_i = 1'b1;
   endtask

   task automatic consume(input string name);
      @(negedge clk);
      vectors++;
      if (rx_valid_o !== 1'b1 || exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s_valid got %b want 1 (queued %0d)", name, rx_valid_o, exp_q.size());
      end else begin
         logic [7:0] e;
         e = exp_q.pop_front();
         if (rx_data_o !== e) begin
            miscompares++;
            $display("FAIL %s_data got %h want %h", name, rx_data_o, e);
         end
      end
      rx_ready_i = 1'b1;
      @(negedge clk);
      rx_ready_i = 1'b0;
      vectors++;
      if (rx_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_clear got %b want 0", name, rx_valid_o);
      end
   endtask

   // Lands on the negedge inside the PRESENT cycle of the frame after the one
   // already counted in p0.
   task automatic wait_second_present(input int p0, output logic ok);
      int n;
      ok = 1'b1;
      n = 0;
      while (pres_n == p0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (bit_cnto != 10'd11 && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (n >= 600 || pres_n == p0) begin
         ok = 1'b0;
         vectors++;
         miscompares++;
         $display("FAIL b2b_timeout got no second frame want PRESENT");
      end else begin
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      #1;
      vectors++;
      if ({sym_o, bit_cnto, rx_data_o, rx_valid_o, busy_o,
           frame_err_o, overrun_o, code_err_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got %h/%h/%h/%b%b%b%b%b want all 0",
                  sym_o, bit_cnto, rx_data_o, rx_valid_o, busy_o,
                  frame_err_o, overrun_o, code_err_o);
      end
      rst = 1'b0;
      tick(4);
      vectors++;
      if (busy_o !== 1'b0 || rx_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy_o, rx_valid_o);
      end
   endtask

   task automatic test_basic(input logic [9:0] s, input string name);
      int p0;
      p0 = pres_n;
      exp_q.push_back(s[7:0] ^ 8'h27);
      send_frame(s, 1'b1);
      tick(2);
      vectors++;
      if (pres_n != p0 + 1 || pres_sym !== s) begin
         miscompares++;
         $display("FAIL %s_present got n=%0d sym=%h want n=%0d sym=%h",
                  name, pres_n - p0, pres_sym, 1, s);
      end
      vectors++;
      if (pres_vb !== 1'b0 || pres_va !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_latency got valid %b->%b want 0->1", name, pres_vb, pres_va);
      end
      consume(name);
   endtask

   task automatic test_glitch;
      int f0, b0, p0, c0;
      f0 = ferr_n;
      b0 = busy_n;
      p0 = pres_n;
      c0 = cerr_n;
      rx_i = 1'b0;
      tick(5);
      rx_i = 1'b1;
      tick(25);
      vectors++;
      if (busy_n == b0 || busy_o !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_busy got seen=%0d now=%b want seen>0 now=0",
                  busy_n - b0, busy_o);
      end
      vectors++;
      if (rx_valid_o !== 1'b0 || ferr_n != f0 || pres_n != p0 || cerr_n != c0) begin
         miscompares++;
         $display("FAIL glitch_quiet got valid=%b ferr=%0d pres=%0d cerr=%0d want 0 0 0 0",
                  rx_valid_o, ferr_n - f0, pres_n - p0, cerr_n - c0);
      end
   endtask

   task automatic test_frame_err;
      logic [9:0] s;
      int f0, p0;
      s = 10'h127;
      f0 = ferr_n;
      p0 = pres_n;
      drive_bit(1'b0);
      for (int i = 0; i < 10; i++) drive_bit(s[i]);
      rx_i = 1'b0;
      tick(40);
      vectors++;
      if (ferr_n != f0 + 1 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL ferr_pulse got pulses=%0d busy=%b want 1 1", ferr_n - f0, busy_o);
      end
      rx_i = 1'b1;
      tick(6);
      vectors++;
      if (busy_o !== 1'b0 || rx_valid_o !== 1'b0 || pres_n != p0 || ferr_n != f0 + 1) begin
         miscompares++;
         $display("FAIL ferr_exit got busy=%b valid=%b pres=%0d want 0 0 0",
                  busy_o, rx_valid_o, pres_n - p0);
      end
   endtask

   task automatic test_back_to_back;
      int p0, o0;
      logic ok;
      // rx_ready_i low throughout: second byte is dropped.
      p0 = pres_n;
      o0 = ovr_n;
      exp_q.push_back(8'h55 ^ 8'h27);
      fork
         begin
            send_frame(10'h155, 1'b1);
            send_frame(10'h0F3, 1'b1);
         end
         begin
            wait_second_present(p0, ok);
            if (ok) begin
               vectors++;
               if (rx_valid_o !== 1'b1 || bit_cnto !== 10'd11 || sym_o !== 10'h0F3) begin
                  miscompares++;
                  $display("FAIL b2b_present got v=%b bc=%0d sym=%h want 1 11 0f3",
                           rx_valid_o, bit_cnto, sym_o);
               end
            end
         end
      join
      tick(3);
      vectors++;
      if (ovr_n != o0 + 1) begin
         miscompares++;
         $display("FAIL b2b_overrun got %0d want 1", ovr_n - o0);
      end
      consume("b2b_keep");
      // Consume in the PRESENT cycle of the second frame: new byte loads.
      p0 = pres_n;
      o0 = ovr_n;
      exp_q.push_back(8'h55 ^ 8'h27);
      exp_q.push_back(8'hF3 ^ 8'h27);
      fork
         begin
            send_frame(10'h155, 1'b1);
            send_frame(10'h0F3, 1'b1);
         end
         begin
            wait_second_present(p0, ok);
            if (ok) begin
               vectors++;
               if (rx_valid_o !== 1'b1 || rx_data_o !== exp_q[0]) begin
                  miscompares++;
                  $display("FAIL b2b_first got v=%b d=%h want 1 %h",
                           rx_valid_o, rx_data_o, exp_q[0]);
               end
               rx_ready_i = 1'b1;
               @(negedge clk);
               rx_ready_i = 1'b0;
               void'(exp_q.pop_front());
            end
         end
      join
      tick(3);
      vectors++;
      if (ovr_n != o0) begin
         miscompares++;
         $display("FAIL b2b_no_overrun got %0d want 0", ovr_n - o0);
      end
      consume("b2b_load");
   endtask

   task automatic test_weight;
      int c0, o0, p0;
      c0 = cerr_n;
      o0 = ovr_n;
      p0 = pres_n;
`ifdef SYM_WEIGHT_CHECK_EN
      send_frame(10'h3FF, 1'b1);
      tick(3);
      vectors++;
      if (cerr_n != c0 + 1 || rx_valid_o !== 1'b0 || ovr_n != o0 || pres_n != p0 + 1) begin
         miscompares++;
         $display("FAIL weight_reject got cerr=%0d valid=%b ovr=%0d want 1 0 0",
                  cerr_n - c0, rx_valid_o, ovr_n - o0);
      end
`else
      exp_q.push_back(8'hFF ^ 8'h27);
      send_frame(10'h3FF, 1'b1);
      tick(3);
      vectors++;
      if (cerr_n != c0 || pres_n != p0 + 1 || ovr_n != o0) begin
         miscompares++;
         $display("FAIL weight_accept got cerr=%0d pres=%0d want 0 1",
                  cerr_n - c0, pres_n - p0);
      end
      consume("weight_data");
`endif
   endtask

   task automatic test_reset_mid;
      logic [9:0] s;
      int f0;
      s = 10'h1E3;
      f0 = ferr_n;
      drive_bit(1'b0);
      for (int i = 0; i < 5; i++) drive_bit(s[i]);
      rx_i = s[5];
      tick(8);
      rst = 1'b1;
      #1;
      vectors++;
      if ({sym_o, bit_cnto, rx_data_o, rx_valid_o, busy_o,
           frame_err_o, overrun_o, code_err_o} !== '0) begin
         miscompares++;
         $display("FAIL midrst_outputs got %h/%h/%h/%b%b want all 0",
                  sym_o, bit_cnto, rx_data_o, rx_valid_o, busy_o);
      end
      rx_i = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(4);
      vectors++;
      if (busy_o !== 1'b0 || bit_cnto !== 10'd0 || ferr_n != f0) begin
         miscompares++;
         $display("FAIL midrst_idle got busy=%b bc=%0d ferr=%0d want 0 0 0",
                  busy_o, bit_cnto, ferr_n - f0);
      end
      test_basic(s, "midrst_frame");
   endtask

   initial begin
      rst = 1'b1;
      rx_i = 1'b1;
      rx_ready_i = 1'b0;
      tick(3);
      test_reset();
      test_basic(10'h127, "basic_127");
      test_basic(10'h2B4, "basic_2b4");
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_weight();
      test_reset_mid();
      tick(4);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule

// File: doc/uart_rx_sym_ctrl.md
Name: uart_rx_sym_ctrl

Overview:
Receive-side sequencer for the UART 10b/8b link. Oversamples the serial line and frames one start bit, ten coded data bits (LSB first) and one stop bit. Presents the assembled 10-bit symbol and bit count to the external combinational 10b-to-8b decoder, captures the decoded byte and hands it to the consumer with a valid/ready handshake. Sits between the rx pin and the UART receive FIFO/host logic.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit; must be at least 4.
CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_i  in  1  serial line, idle high, asynchronous to clk
sym_o  out  10  assembled coded symbol, to decoder data input
bit_cnto  out  10  bit counter, to decoder qualifier; decoder acts only on value 11
dec_data_i  in  8  decoded byte returned by decoder
rx_data_o  out  8  registered received byte
rx_valid_o  out  1  rx_data_o holds an unconsumed byte
rx_ready_i  in  1  consumer accepts the byte on a clk edge with rx_valid_o=1
busy_o  out  1  high in any state other than IDLE
frame_err_o  out  1  one-cycle pulse: stop bit sampled low
overrun_o  out  1  one-cycle pulse: new byte dropped because the previous byte was unconsumed
code_err_o  out  1  one-cycle pulse: illegal symbol weight (see Optional Feature)

Behaviour:
- Reset (async, active-high): all outputs 0; internal rx synchroniser flops = 1; state = IDLE; baud counter = 0; shift register = 0.
- rx_i passes through a 2-flop synchroniser (rx_s). Edge detection uses rx_s only.
- IDLE: bit_cnto=0. rx_s=0 -> START, baud counter cleared.
- START: at baud count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s. If 0 -> DATA, bit_cnto=1, counter cleared. If 1 -> IDLE (glitch rejected, no error).
- DATA: each time the counter reaches CLKS_PER_BIT-1, sample rx_s into sym bit 9 and shift right (first data bit ends in bit 0). Increment bit_cnto. After the 10th data bit, bit_cnto=11 -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s. If 1 -> PRESENT. If 0 -> pulse frame_err_o, discard the symbol, enter BRK.
- BRK: wait for rx_s=1, then IDLE with bit_cnto=0.
- PRESENT: one cycle with bit_cnto=11 and sym_o stable. Capture dec_data_i on the closing edge, then go to IDLE. rx_valid_o is visible on the next cycle. Latency from the stop-bit sample to rx_valid_o is 2 clk.
- Capture rules in PRESENT:
  - rx_valid_o=0: load rx_data_o and set rx_valid_o.
  - rx_valid_o=1 and rx_ready_i=1 in the same cycle: load the new byte and keep rx_valid_o=1. No overrun.
  - rx_valid_o=1 and rx_ready_i=0: keep the old byte and pulse overrun_o.
- Handshake: rx_valid_o holds, with rx_data_o stable, until an edge with rx_ready_i=1, which then clears it. rx_ready_i while rx_valid_o=0 has no effect.
- sym_o holds its last value until the next START->DATA transition clears it to 0.
- Mid-frame reset returns to IDLE immediately. The partial symbol is lost and no pulses are generated.

Optional Feature:
Macro SYM_WEIGHT_CHECK_EN.
- Defined: in PRESENT, the popcount of sym_o must be 4, 5 or 6. Any other weight pulses code_err_o, the byte is not captured, rx_valid_o is unchanged and overrun_o is not pulsed.
- Undefined: code_err_o is tied to 0 and every PRESENT captures.

Test Plan:
- CLKS_PER_BIT=16. Send a frame with symbol 10'b0100100111 (wire order start 0, data 1,1,1,0,0,1,0,0,1,0, stop 1) -> sym_o=0x127, bit_cnto=11 in PRESENT, rx_data_o=0x00, rx_valid_o=1 two clk after the stop sample.
- rx_i low pulse of 5 clk while IDLE -> return to IDLE, busy_o drops, no valid and no error pulse.
- Valid frame with the stop bit driven 0 and the line held low 40 clk -> single frame_err_o pulse, stay in BRK until rx high, rx_valid_o stays 0.
- Two back-to-back frames with rx_ready_i=0 -> first byte retained, one overrun_o pulse. Repeat with rx_ready_i=1 in the PRESENT cycle of the second frame -> second byte loaded, no overrun.
- SYM_WEIGHT_CHECK_EN defined, symbol 0x3FF -> code_err_o pulse, rx_valid_o=0. Macro undefined, same symbol -> rx_valid_o=1, code_err_o=0.
- Assert rst at data bit 5, release it, then send a valid frame -> all outputs 0 after reset and the frame is decoded correctly.
